// File: rtl/kcc_pkg.sv
// Shared types and constants for the keypad code checker.
// Holds the FSM state encoding and BCD digit limits.
package kcc_pkg;

  typedef enum logic [2:0] {
    ENTRY   = 3'd0,
    CHECK   = 3'd1,
    OPEN    = 3'd2,
    FAIL    = 3'd3,
    LOCKOUT = 3'd4
  } kcc_state_e;

  localparam int             BCD_W     = 4;
  localparam logic [BCD_W-1:0] MAX_DIGIT = 4'd9;

endpackage

// File: rtl/keypad_code_checker_key_debounce.sv
// Press debouncer: counts consecutive valid-high samples and emits one accept
// pulse per press, then stays disarmed until valid is seen low.
module key_debounce #(
  parameter int DEBOUNCE = 2
) (
  input  logic clk,
  input  logic rst_ui_n,
  input  logic valid,
  output logic accept
);

  logic [3:0] stable_cnt;
  logic       armed;

  // Combinational so the digit lands in the buffer on the DEBOUNCE-th edge itself.
  assign accept = valid && armed && (stable_cnt == 4'(DEBOUNCE - 1));

  always_ff @(posedge clk or negedge rst_ui_n) begin
    if (!rst_ui_n) begin
      stable_cnt <= '0;
      armed      <= 1'b1;
    end else if (!valid) begin
      stable_cnt <= '0;
      armed      <= 1'b1;
    end else if (accept) begin
      stable_cnt <= '0;
      armed      <= 1'b0;
    end else if (armed) begin
      stable_cnt <= stable_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/keypad_code_checker.sv
// Keypad code checker: debounced BCD digit entry into a shift buffer, passcode
// compare on enter, and an unlock / fail / lockout sequencer.
module keypad_code_checker
  import kcc_pkg::*;
#(
  parameter int                  DIGITS      = 8,
  parameter logic [4*DIGITS-1:0] CODE        = 32'h2193_5488,
  parameter int                  DEBOUNCE    = 2,
  parameter int                  UNLOCK_CYC  = 8,
  parameter int                  MAX_FAILS   = 3,
  parameter int                  LOCKOUT_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst_ui_n,
  input  logic [4:0]            bcd_in,
  input  logic                  enter,
  input  logic                  clr,
  output logic [4*DIGITS-1:0]   digits_out,
  output logic [3:0]            count,
  output logic                  unlocked,
  output logic                  fail,
  output logic                  locked_out,
  output kcc_state_e            fsm_state
);

  localparam int TMR_MAX = (UNLOCK_CYC > LOCKOUT_CYC) ? UNLOCK_CYC : LOCKOUT_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int FC_W    = $clog2(MAX_FAILS + 1);

  // bcd_in[4] is the valid qualifier for bcd_in[3:0]. There is no ready: a
  // debounced press is consumed when accepted and silently dropped whenever
  // the FSM is not in ENTRY, the digit exceeds 9, or the buffer is full.
  logic             accept;
  logic             digit_ok;
  kcc_state_e       state;
  kcc_state_e       state_next;
  logic [TMR_W-1:0] timer;
  logic [FC_W-1:0]  fail_cnt;
  logic [FC_W-1:0]  fail_inc;

  key_debounce #(
    .DEBOUNCE(DEBOUNCE)
  ) u_key_debounce (
    .clk     (clk),
    .rst_ui_n(rst_ui_n),
    .valid   (bcd_in[4]),
    .accept  (accept)
  );

  assign digit_ok  = accept && (bcd_in[BCD_W-1:0] <= MAX_DIGIT) && (count < 4'(DIGITS));
  assign fail_inc  = (fail_cnt == FC_W'(MAX_FAILS)) ? fail_cnt : fail_cnt + FC_W'(1);
  assign fsm_state = state;

  always_comb begin
    state_next = state;
    case (state)
      ENTRY:   if (!clr && enter) state_next = CHECK;
      CHECK:   state_next = ((count == 4'(DIGITS)) && (digits_out == CODE)) ? OPEN : FAIL;
      OPEN:    if (timer == TMR_W'(UNLOCK_CYC - 1)) state_next = ENTRY;
      FAIL:    state_next = (fail_inc == FC_W'(MAX_FAILS)) ? LOCKOUT : ENTRY;
      LOCKOUT: if (timer == TMR_W'(LOCKOUT_CYC - 1)) state_next = ENTRY;
      default: state_next = ENTRY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_ui_n) begin
    if (!rst_ui_n) begin
      state      <= ENTRY;
      timer      <= '0;
      fail_cnt   <= '0;
      digits_out <= '0;
      count      <= '0;
      unlocked   <= 1'b0;
      fail       <= 1'b0;
      locked_out <= 1'b0;
    end else begin
      state      <= state_next;
      // Status flags decode the next state so they track state with no lag.
      unlocked   <= (state_next == OPEN);
      fail       <= (state_next == FAIL);
      locked_out <= (state_next == LOCKOUT);

      if (state_next != state) begin
        timer <= '0;
      end else if (timer != TMR_W'(TMR_MAX)) begin
        timer <= timer + TMR_W'(1);
      end

      case (state)
        ENTRY: begin
          if (clr) begin
            digits_out <= '0;
            count      <= '0;
          end else if (!enter && digit_ok) begin
            digits_out <= {digits_out[4*DIGITS-5:0], bcd_in[BCD_W-1:0]};
            count      <= count + 4'd1;
          end
        end
        OPEN: begin
          if (state_next == ENTRY) begin
            digits_out <= '0;
            count      <= '0;
            fail_cnt   <= '0;
          end
        end
        FAIL: begin
          digits_out <= '0;
          count      <= '0;
          fail_cnt   <= fail_inc;
        end
        LOCKOUT: begin
          if (state_next == ENTRY) fail_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_code_checker.sv
// Directed bench for keypad_code_checker: code entry, debounce, filtering,
// priority, lockout and asynchronous reset, with hand-computed expectations.
module tb_keypad_code_checker;
  import kcc_pkg::*;

  // clock / reset
  logic        clk = 1'b0;
  logic        rst_ui_n;
  logic [4:0]  bcd_in;
  logic        enter;
  logic        clr;
  logic [31:0] digits_out;
  logic [3:0]  count;
  logic        unlocked;
  logic        fail;
  logic        locked_out;
  kcc_state_e  fsm_state;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  keypad_code_checker dut (
    .clk       (clk),
    .rst_ui_n  (rst_ui_n),
    .bcd_in    (bcd_in),
    .enter     (enter),
    .clr       (clr),
    .digits_out(digits_out),
    .count     (count),
    .unlocked  (unlocked),
    .fail      (fail),
    .locked_out(locked_out),
    .fsm_state (fsm_state)
  );

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [3:0] d, input int hold, input int idle);
    bcd_in = {1'b1, d};
    tick(hold);
    bcd_in = 5'd0;
    tick(idle);
  endtask

  task automatic enter_code(input logic [31:0] code);
    for (int i = 7; i >= 0; i--) press(code[4*i +: 4], 5, 5);
  endtask

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_digits"}, digits_out, 32'h0);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_unlocked"}, 32'(unlocked), 32'd0);
    check({tag, "_fail"}, 32'(fail), 32'd0);
    check({tag, "_locked"}, 32'(locked_out), 32'd0);
    check({tag, "_state"}, 32'(fsm_state), 32'(ENTRY));
  endtask

  initial begin
    rst_ui_n = 1'b0;
    bcd_in   = 5'd0;
    enter    = 1'b0;
    clr      = 1'b0;
    tick(2);
    check_idle("reset");
    rst_ui_n = 1'b1;
    tick(2);

    // correct code
    enter_code(32'h2193_5488);
    check("code_digits", digits_out, 32'h2193_5488);
    check("code_count", 32'(count), 32'd8);
    enter = 1'b1;
    tick(1);
    enter = 1'b0;
    check("code_check_state", 32'(fsm_state), 32'(CHECK));
    check("code_unlock_early", 32'(unlocked), 32'd0);
    tick(1);
    check("code_unlock_0", 32'(unlocked), 32'd1);
    for (int i = 1; i < 8; i++) begin
      tick(1);
      check("code_unlock_hold", 32'(unlocked), 32'd1);
    end
    tick(1);
    check_idle("code_after");

    // bounce: one-cycle high gives nothing
    bcd_in = 5'h11;
    tick(1);
    bcd_in = 5'd0;
    tick(3);
    check("bounce_1cyc_count", 32'(count), 32'd0);
    // held key gives exactly one digit
    press(4'd7, 20, 3);
    check("held_count", 32'(count), 32'd1);
    check("held_digits", digits_out, 32'h7);
    // glitch 1,0,1,1
    bcd_in = 5'h13;
    tick(1);
    bcd_in = 5'd0;
    tick(1);
    bcd_in = 5'h13;
    tick(1);
    check("glitch_first_high", 32'(count), 32'd1);
    tick(1);
    check("glitch_accept_count", 32'(count), 32'd2);
    check("glitch_accept_digits", digits_out, 32'h73);
    bcd_in = 5'd0;
    tick(3);

    // invalid digit and overflow
    press(4'hA, 5, 3);
    check("invalid_count", 32'(count), 32'd2);
    check("invalid_digits", digits_out, 32'h73);
    for (int d = 1; d <= 6; d++) press(4'(d), 3, 2);
    check("fill_digits", digits_out, 32'h7312_3456);
    check("fill_count", 32'(count), 32'd8);
    press(4'd9, 3, 2);
    check("overflow_digits", digits_out, 32'h7312_3456);
    check("overflow_count", 32'(count), 32'd8);

    // clr beats enter
    clr   = 1'b1;
    enter = 1'b1;
    tick(1);
    clr   = 1'b0;
    enter = 1'b0;
    check("clr_enter_digits", digits_out, 32'h0);
    check("clr_enter_count", 32'(count), 32'd0);
    check("clr_enter_state", 32'(fsm_state), 32'(ENTRY));
    tick(1);
    check("clr_enter_state2", 32'(fsm_state), 32'(ENTRY));
    check("clr_enter_fail", 32'(fail), 32'd0);

    // lockout after three wrong entries
    for (int a = 1; a <= 3; a++) begin
      for (int k = 0; k < 8; k++) press(4'd1, 3, 2);
      check("wrong_count", 32'(count), 32'd8);
      enter = 1'b1;
      tick(1);
      enter = 1'b0;
      tick(1);
      check("wrong_fail_pulse", 32'(fail), 32'd1);
      tick(1);
      check("wrong_fail_end", 32'(fail), 32'd0);
      check("wrong_count_clr", 32'(count), 32'd0);
      if (a < 3) check("wrong_state", 32'(fsm_state), 32'(ENTRY));
    end
    check("lock_0", 32'(locked_out), 32'd1);
    check("lock_state", 32'(fsm_state), 32'(LOCKOUT));
    for (int i = 1; i < 16; i++) begin
      bcd_in = (i <= 5) ? 5'h12 : 5'd0;
      tick(1);
      check("lock_hold", 32'(locked_out), 32'd1);
    end
    bcd_in = 5'd0;
    tick(1);
    check("lock_end", 32'(locked_out), 32'd0);
    check("lock_end_state", 32'(fsm_state), 32'(ENTRY));
    check("lock_press_ignored", 32'(count), 32'd0);

    enter_code(32'h2193_5488);
    enter = 1'b1;
    tick(1);
    enter = 1'b0;
    tick(1);
    check("post_lock_unlock", 32'(unlocked), 32'd1);
    tick(8);
    check("post_lock_relock", 32'(unlocked), 32'd0);

    // enter beats a simultaneous digit accept
    bcd_in = 5'h15;
    tick(1);
    enter = 1'b1;
    tick(1);
    enter  = 1'b0;
    bcd_in = 5'd0;
    check("enter_digit_state", 32'(fsm_state), 32'(CHECK));
    check("enter_digit_count", 32'(count), 32'd0);
    tick(1);
    check("short_entry_fail", 32'(fail), 32'd1);
    tick(1);
    check("short_entry_state", 32'(fsm_state), 32'(ENTRY));

    // async reset mid-entry
    for (int d = 1; d <= 4; d++) press(4'(d), 3, 2);
    check("mid_entry_digits", digits_out, 32'h1234);
    check("mid_entry_count", 32'(count), 32'd4);
    rst_ui_n = 1'b0;
    #1;
    check_idle("rst_entry");
    tick(1);
    rst_ui_n = 1'b1;
    tick(1);

    // async reset mid-OPEN
    enter_code(32'h2193_5488);
    enter = 1'b1;
    tick(1);
    enter = 1'b0;
    tick(3);
    check("mid_open_unlocked", 32'(unlocked), 32'd1);
    rst_ui_n = 1'b0;
    #1;
    check_idle("rst_open");
    tick(1);
    rst_ui_n = 1'b1;
    tick(2);
    check_idle("rst_release");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
